// File: rtl/decode_stage.sv
// RV32I/RV64I registered decode stage with valid/ready handshakes on both sides.
// Define DECODE_SKID_BUFFER_EN for a skid-buffered variant whose in_ready has no path from out_ready.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_immediate,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam bit IS_RV64 = (XLEN == 64);

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] immediate;
        logic [2:0]      imm_type;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } beat_t;

    logic signed [31:0] imm32;
    logic [2:0]         imm_type;
    logic               illegal;
    beat_t              dec_beat;
    beat_t              out_beat;

    // Every format fits a signed 32-bit value; widening to XLEN is one sign-extending cast.
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        imm32    = '0;
        imm_type = IMM_R;
        illegal  = 1'b0;
        if (in_instruction[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (in_instruction[6:0])
                7'b0110111, 7'b0010111: begin
                    imm32    = {in_instruction[31:12], 12'b0};
                    imm_type = IMM_U;
                end
                7'b1101111: begin
                    imm32    = {{12{in_instruction[31]}}, in_instruction[19:12], in_instruction[20],
                                in_instruction[30:21], 1'b0};
                    imm_type = IMM_J;
                end
                7'b1100011: begin
                    imm32    = {{20{in_instruction[31]}}, in_instruction[7], in_instruction[30:25],
                                in_instruction[11:8], 1'b0};
                    imm_type = IMM_B;
                end
                7'b0100011: begin
                    imm32    = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
                    imm_type = IMM_S;
                end
                7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                    imm32    = {{20{in_instruction[31]}}, in_instruction[31:20]};
                    imm_type = IMM_I;
                end
                7'b0110011: imm_type = IMM_R;
                7'b0011011: begin
                    if (IS_RV64) begin
                        imm32    = {{20{in_instruction[31]}}, in_instruction[31:20]};
                        imm_type = IMM_I;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                7'b0111011: illegal = !IS_RV64;
                default:    illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        dec_beat.opcode    = in_instruction[6:0];
        dec_beat.funct3    = in_instruction[14:12];
        dec_beat.funct7    = in_instruction[31:25];
        dec_beat.rs1       = in_instruction[19:15];
        dec_beat.rs2       = in_instruction[24:20];
        dec_beat.rd        = in_instruction[11:7];
        dec_beat.immediate = XLEN'(imm32);
        dec_beat.imm_type  = imm_type;
        dec_beat.illegal   = illegal;
        dec_beat.pc        = in_pc;
    end

`ifdef DECODE_SKID_BUFFER_EN
    beat_t skid_beat;
    logic  skid_valid;

    // A full skid entry is the only backpressure, so in_ready is independent of out_ready.
    assign in_ready = !skid_valid && !reset && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: payload registers are reset too, since all outputs must read zero after reset.
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // in_ready is low whenever the skid entry is full, so no input collides with the refill.
            if (skid_valid) begin
                out_beat   <= skid_beat;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_beat  <= dec_beat;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid && in_ready) begin
            skid_beat  <= dec_beat;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !reset && !flush && (!out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: payload registers are reset too, since all outputs must read zero after reset.
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_beat  <= dec_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_opcode    = out_beat.opcode;
    assign out_funct3    = out_beat.funct3;
    assign out_funct7    = out_beat.funct7;
    assign out_rs1       = out_beat.rs1;
    assign out_rs2       = out_beat.rs2;
    assign out_rd        = out_beat.rd;
    assign out_immediate = out_beat.immediate;
    assign out_imm_type  = out_beat.imm_type;
    assign out_illegal   = out_beat.illegal;
    assign out_pc        = out_beat.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one XLEN=32 and one XLEN=64 instance share the same stimulus.
// Stall expectations follow DECODE_SKID_BUFFER_EN when it is defined for the build.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_ready;
    logic [63:0] in_pc64;

    logic        rdy32, v32, ill32;
    logic [6:0]  opc32, f7_32;
    logic [2:0]  f3_32, typ32;
    logic [4:0]  rs1_32, rs2_32, rd32;
    logic [31:0] imm32, pc32;

    logic        rdy64, v64, ill64;
    logic [6:0]  opc64, f7_64;
    logic [2:0]  f3_64, typ64;
    logic [4:0]  rs1_64, rs2_64, rd64;
    logic [63:0] imm64, pc64;

    int checks = 0;
    int passes = 0;

    assign in_pc64 = {32'h0, in_pc};

    always #5 clock = ~clock;

    decode_stage #(.XLEN(32)) dut32 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(v32), .out_ready(out_ready),
        .out_opcode(opc32), .out_funct3(f3_32), .out_funct7(f7_32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32),
        .out_immediate(imm32), .out_imm_type(typ32), .out_illegal(ill32), .out_pc(pc32)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instruction(in_instruction), .in_pc(in_pc64),
        .out_valid(v64), .out_ready(out_ready),
        .out_opcode(opc64), .out_funct3(f3_64), .out_funct7(f7_64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64),
        .out_immediate(imm64), .out_imm_type(typ64), .out_illegal(ill64), .out_pc(pc64)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        assert (observed === expected) passes = passes + 1;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_instruction = '0; in_pc = '0; out_ready = 1'b1;
        step(); step();
        check("reset_valid", v32, 0);
        check("reset_in_ready", rdy32, 0);
        check("reset_in_ready64", rdy64, 0);
        check("reset_imm", imm32, 0);
        check("reset_pc", pc32, 0);

        reset = 1'b0;
        drive(32'hFFF10093, 32'h100);
        #1 check("addi_in_ready", rdy32, 1);
        step();
        check("addi_valid", v32, 1);
        check("addi_opcode", opc32, 7'h13);
        check("addi_rd", rd32, 1);
        check("addi_rs1", rs1_32, 2);
        check("addi_imm", imm32, 32'hFFFF_FFFF);
        check("addi_type", typ32, 1);
        check("addi_illegal", ill32, 0);
        check("addi_pc", pc32, 32'h100);
        check("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(32'h00512423, 32'h104);
        step();
        check("sw_valid", v32, 1);
        check("sw_rs1", rs1_32, 2);
        check("sw_rs2", rs2_32, 5);
        check("sw_funct3", f3_32, 2);
        check("sw_imm", imm32, 32'h8);
        check("sw_type", typ32, 2);

        drive(32'hFE000EE3, 32'h108);
        step();
        check("beq_valid", v32, 1);
        check("beq_imm", imm32, 32'hFFFF_FFFC);
        check("beq_type", typ32, 3);
        check("beq_funct7", f7_32, 7'h7F);

        drive(32'h001000EF, 32'h10C);
        step();
        check("jal_imm", imm32, 32'h800);
        check("jal_type", typ32, 5);
        check("jal_rd", rd32, 1);

        drive(32'h123451B7, 32'h110);
        step();
        check("lui_imm", imm32, 32'h1234_5000);
        check("lui_type", typ32, 4);
        check("lui_rd", rd32, 3);
        check("lui_imm64", imm64, 64'h0000_0000_1234_5000);
        check("lui_pc", pc32, 32'h110);

        drive(32'h0000007F, 32'h114);
        step();
        check("op7f_valid", v32, 1);
        check("op7f_illegal", ill32, 1);
        check("op7f_imm", imm32, 0);
        check("op7f_type", typ32, 0);
        check("op7f_opcode", opc32, 7'h7F);

        drive(32'h00000000, 32'h118);
        step();
        check("zero_illegal", ill32, 1);
        check("zero_type", typ32, 0);
        check("zero_illegal64", ill64, 1);

        // addiw x1,x1,-1: OP-IMM-32 only exists on RV64
        drive(32'hFFF0809B, 32'h11C);
        step();
        check("addiw32_illegal", ill32, 1);
        check("addiw32_type", typ32, 0);
        check("addiw32_imm", imm32, 0);
        check("addiw32_rd", rd32, 1);
        check("addiw64_illegal", ill64, 0);
        check("addiw64_type", typ64, 1);
        check("addiw64_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid = 1'b0;
        step();
        check("drain_valid", v32, 0);

        // Stall: out_ready low across three edges while beats keep arriving.
        out_ready = 1'b0;
        drive(32'hFFF10093, 32'h200);
        #1 check("stall_a_ready", rdy32, 1);
        step();
        check("stall_a_valid", v32, 1);
        check("stall_a_pc", pc32, 32'h200);
        drive(32'h00512423, 32'h204);
`ifdef DECODE_SKID_BUFFER_EN
        check("skid_b_ready", rdy32, 1);
        step();
        drive(32'hFE000EE3, 32'h208);
        check("skid_full_ready", rdy32, 0);
        check("skid_hold1_pc", pc32, 32'h200);
        step();
        check("skid_hold2_pc", pc32, 32'h200);
        check("skid_hold2_imm", imm32, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        #1 check("skid_no_comb_ready", rdy32, 0);
        step();
        check("skid_out_b_pc", pc32, 32'h204);
        check("skid_out_b_imm", imm32, 32'h8);
        check("skid_drained_ready", rdy32, 1);
        step();
        check("skid_out_c_valid", v32, 1);
        check("skid_out_c_pc", pc32, 32'h208);
        in_valid = 1'b0;
        step();
        check("skid_end_valid", v32, 0);
`else
        check("stall_b_ready", rdy32, 0);
        step();
        check("stall_hold1_pc", pc32, 32'h200);
        check("stall_hold1_ready", rdy32, 0);
        step();
        check("stall_hold2_pc", pc32, 32'h200);
        check("stall_hold2_imm", imm32, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        #1 check("stall_release_ready", rdy32, 1);
        step();
        check("stall_out_b_valid", v32, 1);
        check("stall_out_b_pc", pc32, 32'h204);
        check("stall_out_b_imm", imm32, 32'h8);
        in_valid = 1'b0;
        step();
        check("stall_end_valid", v32, 0);
`endif

        // Flush while stalled with every holding register occupied.
        out_ready = 1'b0;
        drive(32'hFFF10093, 32'h300);
        step();
`ifdef DECODE_SKID_BUFFER_EN
        drive(32'h00512423, 32'h304);
        step();
`endif
        check("flush_pre_valid", v32, 1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(32'h123451B7, 32'h308);
        #1 check("flush_in_ready", rdy32, 0);
        check("flush_in_ready64", rdy64, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", v32, 0);
        check("flush_valid64", v64, 0);
        step();
        check("flush_no_resurface", v32, 0);

        // Reset while a beat is being held.
        out_ready = 1'b0;
        drive(32'h123451B7, 32'h400);
        step();
        check("rst_pre_valid", v32, 1);
        reset = 1'b1;
        #1 check("rst_in_ready", rdy32, 0);
        step();
        check("rst_valid", v32, 0);
        check("rst_imm", imm32, 0);
        check("rst_pc", pc32, 0);
        check("rst_rd", rd32, 0);
        check("rst_opcode", opc32, 0);
        check("rst_imm64", imm64, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_after_valid", v32, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
